// File: rtl/fm0_fifo_tx.sv
// FM0 backscatter transmitter: drains the byte FIFO into a frame made of the Gen2 preamble,
// the FIFO bytes sent MSB first, and a dummy-1 terminator. Half-bit timing comes from half_period.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | line at 0, waiting for start with a non-empty FIFO
// PREAMBLE | shifting out PRE_PAT, first byte prefetched into hold_q
// SEND     | FM0-encoding shift_q; next byte prefetched during bit 7
// DUMMY    | terminating data-1 bit
// DONE     | single-cycle completion pulse, line back to 0
module fm0_fifo_tx #(
  parameter int                  PRE_LEN = 12,
  parameter logic [PRE_LEN-1:0]  PRE_PAT = 12'b110100100011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] half_period,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(PRE_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SEND,
    S_DUMMY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         cnt_q;
  logic [8:0]         hp_q;
  logic [8:0]         hp_clamped;
  logic [PW-1:0]      pre_idx_q;
  logic [PRE_LEN-1:0] pre_sr_q;
  logic [2:0]         bit_idx_q;
  logic               phase_q;
  logic [7:0]         shift_q;
  logic [7:0]         hold_q;
  logic               hold_valid_q;
  logic               rd_pend_q;
  logic               tx_q;

  logic tick;
  logic accept;
  logic prefetch;
  logic pre_last;
  logic byte_end;
  logic active;

  assign hp_clamped = (half_period < 9'd2) ? 9'd2 : half_period;
  assign tick       = (cnt_q == hp_q - 9'd1);
  assign active     = (state_q == S_PREAMBLE) || (state_q == S_SEND) || (state_q == S_DUMMY);
  assign accept     = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !fifo_empty;
  assign pre_last   = (pre_idx_q == PW'(PRE_LEN - 1));
  assign byte_end   = phase_q && (bit_idx_q == 3'd7);

  // Next byte is requested on the first clock of the last bit, leaving a full bit to land in hold_q.
  assign prefetch   = (state_q == S_SEND) && (bit_idx_q == 3'd7) && !phase_q &&
                      (cnt_q == 9'd0) && !hold_valid_q && !fifo_empty;

  assign fifo_read  = !reset && (accept || prefetch);
  assign busy       = active;
  assign done       = (state_q == S_DONE);
  assign tx_out     = tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (tick && pre_last) state_d = S_SEND;
      end
      S_SEND: begin
        if (tick && byte_end && !hold_valid_q) state_d = S_DUMMY;
      end
      S_DUMMY: begin
        if (tick && phase_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = accept ? S_PREAMBLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      hp_q         <= 9'd2;
      pre_idx_q    <= '0;
      pre_sr_q     <= '0;
      bit_idx_q    <= '0;
      phase_q      <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      tx_q         <= 1'b0;
    end else begin
      rd_pend_q <= fifo_read;

      if (accept) begin
        hp_q         <= hp_clamped;
        cnt_q        <= '0;
        pre_idx_q    <= '0;
        pre_sr_q     <= PRE_PAT;
        tx_q         <= PRE_PAT[PRE_LEN-1];
        bit_idx_q    <= '0;
        phase_q      <= 1'b0;
        hold_valid_q <= 1'b0;
      end else if (active) begin
        cnt_q <= tick ? 9'd0 : cnt_q + 9'd1;
        if (tick) begin
          case (state_q)
            S_PREAMBLE: begin
              if (pre_last) begin
                shift_q      <= hold_q;
                hold_valid_q <= 1'b0;
                bit_idx_q    <= '0;
                phase_q      <= 1'b0;
                tx_q         <= ~tx_q;
              end else begin
                pre_idx_q <= pre_idx_q + PW'(1);
                pre_sr_q  <= {pre_sr_q[PRE_LEN-2:0], 1'b0};
                tx_q      <= pre_sr_q[PRE_LEN-2];
              end
            end
            S_SEND: begin
              if (!phase_q) begin
                phase_q <= 1'b1;
                if (!shift_q[7]) tx_q <= ~tx_q;
              end else begin
                phase_q <= 1'b0;
                tx_q    <= ~tx_q;
                if (bit_idx_q == 3'd7) begin
                  if (hold_valid_q) begin
                    shift_q      <= hold_q;
                    hold_valid_q <= 1'b0;
                    bit_idx_q    <= '0;
                  end
                end else begin
                  bit_idx_q <= bit_idx_q + 3'd1;
                  shift_q   <= {shift_q[6:0], 1'b0};
                end
              end
            end
            S_DUMMY: begin
              if (!phase_q) begin
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                tx_q    <= 1'b0;
              end
            end
            default: tx_q <= 1'b0;
          endcase
        end
      end else begin
        cnt_q <= '0;
        tx_q  <= 1'b0;
      end

      // FIFO read data is valid the cycle after the pop strobe.
      if (rd_pend_q) begin
        hold_q       <= fifo_data;
        hold_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fm0_fifo_tx.sv
// Self-checking bench for fm0_fifo_tx: a queue-based FIFO, a half-bit level model of the FM0 frame,
// and directed plus random frames compared cycle by cycle.
module tb_fm0_fifo_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] half_period;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;
  logic       tx_out;
  logic       busy;
  logic       done;

  fm0_fifo_tx dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .half_period (half_period),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read   (fifo_read),
    .tx_out      (tx_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         rd_cnt   = 0;
  int         viol     = 0;
  int         done_cnt = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] frame_bytes[$];
  bit         exp_lv[$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: service the FIFO pop at the rising edge, then return at the falling edge.
  task automatic step();
    logic [7:0] v;
    @(posedge clk);
    if (fifo_read) begin
      rd_cnt++;
      if (fifo_empty || fifo_q.size() == 0) begin
        viol++;
      end else begin
        v = fifo_q.pop_front();
        fifo_data <= v;
      end
    end
    if (done) done_cnt++;
    fifo_empty <= (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Expected half-bit levels: preamble, FM0 data (boundary flip, extra mid flip for 0), dummy 1.
  task automatic build_exp();
    logic [11:0] pre;
    bit          lvl;
    pre = 12'b110100100011;
    exp_lv.delete();
    for (int i = 11; i >= 0; i--) exp_lv.push_back(pre[i]);
    lvl = 1'b1;
    foreach (frame_bytes[k]) begin
      for (int b = 7; b >= 0; b--) begin
        lvl = ~lvl;
        exp_lv.push_back(lvl);
        if (frame_bytes[k][b] == 1'b0) lvl = ~lvl;
        exp_lv.push_back(lvl);
      end
    end
    lvl = ~lvl;
    exp_lv.push_back(lvl);
    exp_lv.push_back(lvl);
  endtask

  task automatic run_frame(input int hp_in, input int nbytes, input string tag);
    int hpe;
    int n;
    int rd0;
    int dn0;
    int bad_tx;
    int bad_busy;
    hpe = (hp_in < 2) ? 2 : hp_in;
    n   = exp_lv.size();
    rd0 = rd_cnt;
    half_period = 9'(hp_in);
    start = 1'b1;
    #1;
    chk(fifo_read, 1'b1, {tag, "_rd_on_start"});
    step();
    start = 1'b0;
    dn0 = done_cnt;
    bad_tx = 0;
    bad_busy = 0;
    for (int j = 0; j < n * hpe; j++) begin
      if (tx_out !== exp_lv[j / hpe]) begin
        if (bad_tx == 0) chk(tx_out, exp_lv[j / hpe], {tag, "_tx_level"});
        bad_tx++;
      end
      if (busy !== 1'b1 || done !== 1'b0) begin
        if (bad_busy == 0) chk({busy, done}, 2'b10, {tag, "_busy_in_frame"});
        bad_busy++;
      end
      step();
    end
    chk(bad_tx, 0, {tag, "_tx_mismatch_cycles"});
    chk(bad_busy, 0, {tag, "_busy_mismatch_cycles"});
    chk({done, busy, tx_out}, 3'b100, {tag, "_done_cycle"});
    step();
    chk({done, busy, tx_out}, 3'b000, {tag, "_after_done"});
    chk(done_cnt - dn0, 1, {tag, "_done_pulses"});
    chk(rd_cnt - rd0, nbytes, {tag, "_fifo_reads"});
    chk(viol, 0, {tag, "_read_while_empty"});
  endtask

  initial begin
    logic [29:0] lit;
    logic [7:0]  b0, b1, b2;
    int          nb, hp;
    int          bad;

    reset       = 1'b1;
    start       = 1'b0;
    half_period = 9'd2;
    fifo_empty  = 1'b1;
    fifo_data   = 8'h00;
    repeat (3) step();
    chk({tx_out, busy, done, fifo_read}, 4'b0000, "reset_outputs");
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if ({tx_out, busy, fifo_read, done} !== 4'b0000) bad++;
      step();
    end
    chk(bad, 0, "idle_100_cycles");

    // 0xA5 at half_period 2, checked against the literal half-bit sequence.
    lit = 30'b110100100011_00_10_11_01_01_00_10_11_00;
    exp_lv.delete();
    for (int i = 29; i >= 0; i--) exp_lv.push_back(lit[i]);
    push_byte(8'hA5);
    step();
    run_frame(2, 1, "a5_hp2");

    // half_period 0 and 1 clamp to 2.
    push_byte(8'hA5);
    step();
    run_frame(0, 1, "a5_hp0");
    push_byte(8'hA5);
    step();
    run_frame(1, 1, "a5_hp1");

    // 0x00 then 0xFF at half_period 3: 46 half-bits.
    frame_bytes = '{8'h00, 8'hFF};
    build_exp();
    chk(exp_lv.size() * 3, 138, "len_00_ff");
    push_byte(8'h00);
    push_byte(8'hFF);
    step();
    run_frame(3, 2, "00_ff_hp3");

    // start with an empty FIFO is ignored.
    start = 1'b1;
    #1;
    chk(fifo_read, 1'b0, "empty_start_rd");
    step();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({tx_out, busy, fifo_read} !== 3'b000) bad++;
      step();
    end
    chk(bad, 0, "empty_start_idle");

    // Random frames.
    for (int t = 0; t < 6; t++) begin
      nb = $urandom_range(1, 4);
      hp = $urandom_range(0, 5);
      frame_bytes.delete();
      for (int k = 0; k < nb; k++) begin
        b0 = 8'($urandom);
        frame_bytes.push_back(b0);
        push_byte(b0);
      end
      build_exp();
      step();
      run_frame(hp, nb, $sformatf("rand%0d", t));
    end

    // Reset in the middle of the first byte of a 3-byte frame.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    push_byte(b0);
    push_byte(b1);
    push_byte(b2);
    step();
    half_period = 9'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b1) bad++;
      step();
    end
    chk(bad, 0, "abort_busy_before");
    nb = done_cnt;
    reset = 1'b1;
    step();
    chk({tx_out, busy, done}, 3'b000, "abort_next_cycle");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk(done_cnt - nb, 0, "abort_no_done");
    chk(fifo_q.size(), 2, "abort_fifo_left");
    frame_bytes = '{b1, b2};
    build_exp();
    run_frame(2, 2, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
